dds_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO for the DDS datapath. It buffers frequency, phase and amplitude command

---
 rtl/dds_fifo_pkg.sv | 21 ++
 rtl/dds_sync_fifo_if.sv | 32 +++
 rtl/dds_fifo_ram.sv | 26 ++
 rtl/dds_sync_fifo.sv | 118 +++++++++++
 tb/tb_dds_sync_fifo.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dds_fifo_pkg.sv
// Shared definitions for the DDS command FIFO: address-width helper, command width, level type.
package dds_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DDS_CMD_W      = 40;
  localparam int DDS_FIFO_DEPTH = 128;

  typedef logic [clog2(DDS_FIFO_DEPTH):0] fifo_level_t;

endpackage

// File: rtl/dds_sync_fifo_if.sv
// Push/pop handshake, status and monitor signals between a FIFO (slave) and its user (master).
interface dds_sync_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
);
  import dds_fifo_pkg::*;

  localparam int LVL_W = clog2(DEPTH) + 1;

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic [15:0]       drop_cnt;

  modport master (
    output flush, wr_en, wr_data, rd_ready,
    input  full, rd_valid, rd_data, level, almost_full, almost_empty, overflow, drop_cnt
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_ready,
    output full, rd_valid, rd_data, level, almost_full, almost_empty, overflow, drop_cnt
  );
endinterface

// File: rtl/dds_fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module dds_fifo_ram
  import dds_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dds_sync_fifo.sv
// Single-clock FWFT FIFO with level, watermarks and flush; the dropped-write
// monitor (overflow, drop_cnt) is built only when DDS_FIFO_ERR_EN is defined.
module dds_sync_fifo
  import dds_fifo_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 128,
  parameter int AFULL_THRESH  = 120,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic           clk,
  input  logic           rst,
  dds_sync_fifo_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] AFULL_L  = AFULL_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_L = AEMPTY_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            rd_valid;
  logic            push;
  logic            pop;

  assign rd_valid = (wr_ptr_q != rd_ptr_q);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    push     = bus.wr_en && !full_q && !bus.flush;
    pop      = rd_valid && bus.rd_ready && !bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end
    full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
               (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    afull_d  = (level_d >= AFULL_L);
    aempty_d = (level_d <= AEMPTY_L);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  dds_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (bus.rd_data)
  );

`ifdef DDS_FIFO_ERR_EN
  logic        overflow_q;
  logic [15:0] drop_cnt_q;
  logic        drop;

  assign drop = bus.wr_en && full_q && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (bus.flush) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.overflow = 1'b0;
  assign bus.drop_cnt = '0;
`endif

  assign bus.full         = full_q;
  assign bus.rd_valid     = rd_valid;
  assign bus.level        = level_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;

endmodule

// File: tb/tb_dds_sync_fifo.sv
// Scoreboard bench for dds_sync_fifo at default parameters (honours DDS_FIFO_ERR_EN).
module tb_dds_sync_fifo;
  import dds_fifo_pkg::*;

  localparam int DEPTH = 128;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] q[$];

  dds_sync_fifo_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

  dds_sync_fifo #(
    .DATA_W        (8),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (120),
    .AEMPTY_THRESH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; outputs are sampled at the falling edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
    int sz;
    bus.wr_en    = wr;
    bus.wr_data  = d;
    bus.rd_ready = rd;
    bus.flush    = fl;
    @(negedge clk);
    sz = q.size();
    n_cmp++;
    if (bus.rd_valid !== (sz != 0)) begin
      n_err++;
      $display("FAIL rd_valid: got %b want %b", bus.rd_valid, (sz != 0));
    end
    if (rd && sz != 0) begin
      n_cmp++;
      if (bus.rd_data !== q[0]) begin
        n_err++;
        $display("FAIL rd_data: got %h want %h", bus.rd_data, q[0]);
      end
    end
    if (fl) begin
      q.delete();
    end else begin
      if (rd && sz != 0) void'(q.pop_front());
      if (wr && sz < DEPTH) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.rd_valid, bus.full, bus.almost_empty, bus.almost_full, bus.overflow} !== 5'b00100 ||
        bus.level !== 8'd0 || bus.drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset: got v%b f%b ae%b af%b ov%b lvl%0d drop%0d want v0 f0 ae1 af0 ov0 lvl0 drop0",
               bus.rd_valid, bus.full, bus.almost_empty, bus.almost_full, bus.overflow,
               bus.level, bus.drop_cnt);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    fifo_level_t exp_lvl;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      exp_lvl = fifo_level_t'(q.size());
      n_cmp++;
      if (bus.level !== exp_lvl || bus.almost_full !== (q.size() >= 120)) begin
        n_err++;
        $display("FAIL fill_level: got lvl%0d af%b want lvl%0d af%b",
                 bus.level, bus.almost_full, exp_lvl, (q.size() >= 120));
      end
    end
    n_cmp++;
    if (bus.full !== 1'b1 || bus.level !== 8'd128) begin
      n_err++;
      $display("FAIL full: got f%b lvl%0d want f1 lvl128", bus.full, bus.level);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.level !== 8'd0 || bus.almost_empty !== 1'b1 || bus.full !== 1'b0) begin
      n_err++;
      $display("FAIL drained: got v%b lvl%0d ae%b f%b want v0 lvl0 ae1 f0",
               bus.rd_valid, bus.level, bus.almost_empty, bus.full);
    end
  endtask

  task automatic test_overflow();
    logic        exp_ovf;
    logic [15:0] exp_drop;
`ifdef DDS_FIFO_ERR_EN
    exp_ovf = 1'b1; exp_drop = 16'd1;
`else
    exp_ovf = 1'b0; exp_drop = 16'd0;
`endif
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 3), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    n_cmp++;
    if (bus.overflow !== exp_ovf || bus.drop_cnt !== exp_drop || bus.level !== 8'd128) begin
      n_err++;
      $display("FAIL overflow: got ov%b drop%0d lvl%0d want ov%b drop%0d lvl128",
               bus.overflow, bus.drop_cnt, bus.level, exp_ovf, exp_drop);
    end
    // Push while full with a pop in the same cycle: the push must still be refused.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    n_cmp++;
    if (bus.level !== 8'd127 || bus.full !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop_push: got lvl%0d f%b want lvl127 f0", bus.level, bus.full);
    end
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL overflow_drain: got v%b ov%b want v0 ov%b", bus.rd_valid, bus.overflow, exp_ovf);
    end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      if (bus.level !== 8'd5) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wrap_level: got %0d cycles with level!=5 want 0", bad);
    end
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i ^ 8'h5A), 1'b0, 1'b0);
    n_cmp++;
    if (bus.level !== 8'd64) begin
      n_err++;
      $display("FAIL flush_pre: got lvl%0d want 64", bus.level);
    end
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    n_cmp++;
    if (bus.level !== 8'd0 || bus.rd_valid !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.drop_cnt !== 16'd0 || bus.almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL flush: got lvl%0d v%b ov%b drop%0d ae%b want lvl0 v0 ov0 drop0 ae1",
               bus.level, bus.rd_valid, bus.overflow, bus.drop_cnt, bus.almost_empty);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0);
    bus.wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.level !== 8'd0 || bus.almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got v%b lvl%0d ae%b want v0 lvl0 ae1",
               bus.rd_valid, bus.level, bus.almost_empty);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    step(1'b1, 8'h3D, 1'b0, 1'b0);
    n_cmp++;
    if (bus.level !== 8'd2) begin
      n_err++;
      $display("FAIL post_reset_level: got %0d want 2", bus.level);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
